// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only slave receiver.
package i2c_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [BYTE_W-1:0] DEFAULT_SLAVE_ADDR = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    WAIT_STOP
  } i2c_state_e;

  // Insert one received bit into the byte being assembled.
  function automatic logic [BYTE_W-1:0] shift_bit(
    input logic [BYTE_W-1:0] cur,
    input logic              b,
    input logic              lsb_first
  );
    return lsb_first ? {b, cur[BYTE_W-1:1]} : {cur[BYTE_W-2:0], b};
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Input synchronizer plus history flop for one bus line; flags rise/fall.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Preset to 1 so an idle bus produces no edges out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C-style write-only slave receiver: START/STOP detect, address match,
// open-drain ACK and a one-cycle strobe per received data byte.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic              LSB_FIRST   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SCL_IN,
  input  logic              SDA_IN,
  output logic              SDA_OE,
  output logic [BYTE_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              ADDR_HIT,
  output logic              BUSY
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    shift_q, shift_d, shifted;
  logic [BYTE_W-1:0]    rx_data_q, rx_data_d;
  logic                 ack_hi_q, ack_hi_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 addr_hit_q, addr_hit_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 last_bit;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk     (CLK),
    .rst_n   (RST_N),
    .line_in (SCL_IN),
    .level   (scl_level),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk     (CLK),
    .rst_n   (RST_N),
    .line_in (SDA_IN),
    .level   (sda_level),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  assign start_det = sda_fall & scl_level;
  assign stop_det  = sda_rise & scl_level;
  assign shifted   = shift_bit(shift_q, sda_level, LSB_FIRST);
  assign last_bit  = (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      ack_hi_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      addr_hit_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      ack_hi_q   <= ack_hi_d;
      sda_oe_q   <= sda_oe_d;
      addr_hit_q <= addr_hit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Next-state, bit assembly and ACK driver; START/STOP override SCL edges.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ack_hi_d   = ack_hi_q;
    sda_oe_d   = sda_oe_q;
    addr_hit_d = addr_hit_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    // Completed byte is published one cycle after its last bit is shifted in.
    rx_valid_d = done_q;
    rx_data_d  = done_q ? shift_q : rx_data_q;

    if (stop_det) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      ack_hi_d   = 1'b0;
      sda_oe_d   = 1'b0;
      addr_hit_d = 1'b0;
      busy_d     = 1'b0;
    end else if (start_det) begin
      state_d    = ADDR;
      bit_cnt_d  = '0;
      ack_hi_d   = 1'b0;
      sda_oe_d   = 1'b0;
      addr_hit_d = 1'b0;
      busy_d     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) begin
              state_d = (shifted == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) begin
              done_d  = 1'b1;
              state_d = DATA_ACK;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_hi_q) begin
              sda_oe_d = 1'b1;
              ack_hi_d = 1'b1;
              if (state_q == ADDR_ACK) begin
                addr_hit_d = 1'b1;
              end
            end else begin
              sda_oe_d  = 1'b0;
              ack_hi_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = DATA;
            end
          end
        end
        WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign SDA_OE   = sda_oe_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign ADDR_HIT = addr_hit_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Scoreboard bench for i2c_slave_rx driven by a behavioural bus master.
module tb_i2c_slave_rx;

  localparam logic [7:0]  SLAVE_ADDR  = i2c_pkg::DEFAULT_SLAVE_ADDR;
  localparam int unsigned SYNC_STAGES = 2;
  localparam logic        LSB_FIRST   = 1'b1;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       scl;
  logic       sda_m;
  logic       sda_in;
  logic       SDA_OE;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       ADDR_HIT;
  logic       BUSY;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rise = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_byte = 8'h00;
  logic       prev_valid = 1'b0;

  assign sda_in = sda_m & ~SDA_OE;

  i2c_slave_rx #(
    .SLAVE_ADDR  (SLAVE_ADDR),
    .SYNC_STAGES (SYNC_STAGES),
    .LSB_FIRST   (LSB_FIRST)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .SCL_IN   (scl),
    .SDA_IN   (sda_in),
    .SDA_OE   (SDA_OE),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .ADDR_HIT (ADDR_HIT),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: every RX_VALID strobe is matched against the scoreboard.
  always @(negedge CLK) begin
    if (RX_VALID) begin
      chk("rx_valid_width", prev_valid, 1'b0);
      chk("rx_latency", cyc - last_rise, SYNC_STAGES + 2);
      if (exp_q.size() == 0) begin
        chk("unexpected_rx_valid", 1'b1, 1'b0);
      end else begin
        chk("rx_data", RX_DATA, exp_q.pop_front());
      end
    end
    prev_valid = RX_VALID;
  end

  // SCL period is 16 CLK cycles; SDA changes mid-way through SCL low.
  task automatic send_bit(input logic b);
    wt(4); sda_m = b;
    wt(4); scl = 1'b1; last_rise = cyc;
    wt(8); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(LSB_FIRST ? v[i] : v[7-i]);
  endtask

  task automatic ack_slot(input logic exp_ack, input string name);
    wt(4); sda_m = 1'b1;
    wt(4); scl = 1'b1; last_rise = cyc;
    wt(4); chk(name, SDA_OE, exp_ack);
    wt(4); scl = 1'b0;
  endtask

  task automatic send_start();
    sda_m = 1'b1; wt(4);
    scl = 1'b1;   wt(4);
    sda_m = 1'b0; wt(8);
    scl = 1'b0;
  endtask

  task automatic send_stop();
    wt(4); sda_m = 1'b0;
    wt(4); scl = 1'b1;
    wt(8); sda_m = 1'b1;
    wt(8);
  endtask

  // Reference model: the slave accepts a transfer iff the address matches;
  // then every full data byte is ACKed and delivered in order.
  task automatic write_txn(input logic [7:0] addr, input logic [7:0] d [4], input int n);
    bit hit;
    hit = (addr == SLAVE_ADDR);
    send_start();
    chk("busy_after_start", BUSY, 1'b1);
    send_byte(addr);
    ack_slot(hit, "addr_ack");
    chk("addr_hit", ADDR_HIT, hit);
    for (int i = 0; i < n; i++) begin
      if (hit) begin
        exp_q.push_back(d[i]);
        last_byte = d[i];
      end
      send_byte(d[i]);
      ack_slot(hit, "data_ack");
    end
    send_stop();
    chk("busy_after_stop", BUSY, 1'b0);
    chk("addr_hit_after_stop", ADDR_HIT, 1'b0);
    chk("sda_oe_after_stop", SDA_OE, 1'b0);
    chk("rx_data_hold", RX_DATA, last_byte);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d [4];
    logic [7:0] a, b;
    int n;

    RST_N = 1'b0; scl = 1'b1; sda_m = 1'b1;
    wt(3);
    chk("rst_sda_oe", SDA_OE, 1'b0);
    chk("rst_rx_data", RX_DATA, 8'h00);
    chk("rst_rx_valid", RX_VALID, 1'b0);
    chk("rst_addr_hit", ADDR_HIT, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    RST_N = 1'b1;
    wt(8);

    // Single byte to own address.
    write_txn(8'h5A, '{8'hC3, 8'h00, 8'h00, 8'h00}, 1);
    // Foreign address: no ACK, no data.
    write_txn(8'h5B, '{8'h77, 8'h00, 8'h00, 8'h00}, 1);
    // Multi-byte write.
    write_txn(8'h5A, '{8'h01, 8'hFF, 8'h80, 8'h00}, 3);

    // STOP after 5 data bits: partial byte discarded.
    send_start();
    send_byte(SLAVE_ADDR);
    ack_slot(1'b1, "partial_addr_ack");
    b = 8'($urandom);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    send_stop();
    chk("partial_rx_data", RX_DATA, last_byte);
    chk("partial_sda_oe", SDA_OE, 1'b0);
    chk("partial_busy", BUSY, 1'b0);

    // Repeated START after address ACK.
    send_start();
    send_byte(SLAVE_ADDR);
    ack_slot(1'b1, "rs_addr_ack1");
    chk("rs_addr_hit1", ADDR_HIT, 1'b1);
    send_start();
    chk("rs_addr_hit_cleared", ADDR_HIT, 1'b0);
    chk("rs_busy", BUSY, 1'b1);
    send_byte(SLAVE_ADDR);
    ack_slot(1'b1, "rs_addr_ack2");
    chk("rs_addr_hit2", ADDR_HIT, 1'b1);
    exp_q.push_back(8'hA5); last_byte = 8'hA5;
    send_byte(8'hA5);
    ack_slot(1'b1, "rs_data_ack");
    send_stop();
    chk("rs_rx_data", RX_DATA, 8'hA5);

    // Asynchronous reset while driving the data ACK.
    send_start();
    send_byte(SLAVE_ADDR);
    ack_slot(1'b1, "rr_addr_ack");
    b = 8'($urandom);
    exp_q.push_back(b); last_byte = b;
    send_byte(b);
    wt(4); sda_m = 1'b1;
    wt(4);
    chk("rr_oe_before_reset", SDA_OE, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    chk("rr_sda_oe", SDA_OE, 1'b0);
    chk("rr_rx_data", RX_DATA, 8'h00);
    chk("rr_rx_valid", RX_VALID, 1'b0);
    chk("rr_addr_hit", ADDR_HIT, 1'b0);
    chk("rr_busy", BUSY, 1'b0);
    last_byte = 8'h00;
    scl = 1'b1; sda_m = 1'b1;
    wt(3);
    RST_N = 1'b1;
    wt(8);
    write_txn(8'h5A, '{8'h3C, 8'h00, 8'h00, 8'h00}, 1);

    // Randomized transfers.
    for (int t = 0; t < 8; t++) begin
      a = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      write_txn(a, d, n);
    end

    wt(20);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
